data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL take parameter DEPTH_WORDS, default 256, giving the number of 32-bit words of storage (power of two, 4..65536).
REQ-002 The block SHALL take parameter WAIT_CYCLES, default 2, giving the number of wait states inserted before each response (0..15).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 mem_valid_i  input  1  initiator request valid; held high until mem_ready_o is seen.
REQ-007 mem_addr_i  input  32  byte address of the access.
REQ-008 mem_wdata_i  input  32  store data.
REQ-009 mem_wstrb_i  input  4  byte write enables; 4'b0000 means load, any nonzero value means store.
REQ-010 mem_ready_o  output  1  one-cycle response strobe.
REQ-011 mem_rdata_o  output  32  load data, valid only while mem_ready_o=1.
REQ-012 mem_err_o  output  1  access fault, valid only while mem_ready_o=1.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP, with state, wait counter and captured request all registered.
REQ-014 In IDLE with mem_valid_i=1, the block SHALL capture addr/wdata/wstrb on that edge and enter WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 In IDLE with mem_valid_i=0, the block SHALL remain in IDLE.
REQ-016 In WAIT, a 4-bit counter loaded with WAIT_CYCLES-1 at capture SHALL decrement each cycle; at count 0 the FSM SHALL go to RESP.
REQ-017 In WAIT, if mem_valid_i=0 the request SHALL be aborted: return to IDLE, no response, no write.
REQ-018 RESP SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-019 mem_ready_o SHALL be 1 exactly when the state is RESP.
REQ-020 Latency SHALL be WAIT_CYCLES+1: the accepting edge at cycle N puts mem_ready_o high during cycle N+WAIT_CYCLES+1.
REQ-021 The fault condition is captured addr[1:0]!=0 or captured addr[31:2]>=DEPTH_WORDS.
REQ-022 Without a fault, the word index SHALL be addr[2+:log2(DEPTH_WORDS)].
REQ-023 In RESP with no fault and wstrb=0, mem_rdata_o SHALL be the addressed word; mem_err_o SHALL be 0.
REQ-024 In RESP with no fault and wstrb!=0, byte k (bits 8k+7:8k) of the addressed word SHALL be updated at the edge ending RESP for each wstrb[k]=1; unstrobed bytes are unchanged; mem_rdata_o SHALL be 0.
REQ-025 In RESP with a fault, mem_err_o SHALL be 1, mem_rdata_o SHALL be 0 and no write SHALL occur.
REQ-026 Outside RESP, mem_rdata_o and mem_err_o SHALL be 0.
REQ-027 Input changes after capture SHALL be ignored; only the captured request is serviced.
REQ-028 If mem_valid_i is still high in the IDLE cycle after RESP, it SHALL be treated as a new request (back-to-back accesses), giving one response per WAIT_CYCLES+2 cycles.
REQ-029 A load issued after a store to the same word SHALL return the updated data.

Reset
REQ-030 When rst_i=1 at a rising edge, the block SHALL enter IDLE, clear the counter and captured request, and drive mem_ready_o, mem_rdata_o and mem_err_o to 0 from the next cycle.
REQ-031 Reset SHALL take priority over every transition, including mid-WAIT and in RESP; an interrupted store SHALL NOT write.
REQ-032 Reset SHALL NOT clear storage contents; storage is undefined after power-up.

Verification
REQ-033 Store/load, WAIT_CYCLES=2: SW addr 0x10, data 0xDEADBEEF, wstrb 1111 -> ready 3 cycles after accept, err=0; then LW 0x10 -> rdata 0xDEADBEEF.
REQ-034 Byte strobe: word 0x20 holds 0x11223344; store 0xAABBCCDD with wstrb 0101 -> load returns 0x11BB33DD.
REQ-035 Faults, DEPTH_WORDS=256: LW 0x402 -> ready with err=1, rdata 0; SW 0x400 -> err=1; a later load of index 0 is unchanged.
REQ-036 Abort: valid drops in the first WAIT cycle of a store -> no ready pulse, FSM in IDLE next cycle, target word unchanged.
REQ-037 Reset mid-operation: rst_i asserted during WAIT of a store -> ready stays 0, word unchanged, and a new request is accepted the cycle after rst_i deasserts.
REQ-038 WAIT_CYCLES=0 with valid held high -> ready pulses every 2nd cycle, each with the correct data.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request port.
// Each accepted request is answered with a one-cycle response after WAIT_CYCLES wait states.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic        capture;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          fault;
  logic          is_resp;
  logic          do_write;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        addr_q  <= mem_addr_i;
        wdata_q <= mem_wdata_i;
        wstrb_q <= mem_wstrb_i;
      end
    end
  end

  // Dropping valid while waiting abandons the request; the abort check wins over expiry.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mem_valid_i) begin
          capture    = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (!mem_valid_i) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt == '0) begin
          state_next = S_RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // DEPTH_WORDS is a power of two, so "index out of range" is any set bit above the index field.
  assign idx      = addr_q[2 +: AW];
  assign fault    = (|addr_q[1:0]) | (|addr_q[31:2+AW]);
  assign is_resp  = (state == S_RESP);
  assign do_write = is_resp && !fault && (|wstrb_q) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (wstrb_q[k]) begin
          mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    mem_ready_o = is_resp;
    mem_err_o   = is_resp && fault;
    mem_rdata_o = '0;
    if (is_resp && !fault && (wstrb_q == '0)) begin
      mem_rdata_o = mem[idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance checked against an array model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  logic [31:0] model [2][256];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .mem_valid_i(valid[0]), .mem_addr_i(addr[0]), .mem_wdata_i(wdata[0]), .mem_wstrb_i(wstrb[0]),
    .mem_ready_o(ready[0]), .mem_rdata_o(rdata[0]), .mem_err_o(err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .mem_valid_i(valid[1]), .mem_addr_i(addr[1]), .mem_wdata_i(wdata[1]), .mem_wstrb_i(wstrb[1]),
    .mem_ready_o(ready[1]), .mem_rdata_o(rdata[1]), .mem_err_o(err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd256);
  endfunction

  function automatic logic [31:0] exp_rdata(input int d, input logic [31:0] a, input logic [3:0] ws);
    if (is_fault(a) || ws != 4'b0000) return 32'h0;
    return model[d][int'(a >> 2)];
  endfunction

  task automatic model_update(input int d, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws);
    if (!is_fault(a) && ws != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        if (ws[k]) model[d][int'(a >> 2)][8*k +: 8] = wd[8*k +: 8];
      end
    end
  endtask

  task automatic pick(output logic [31:0] a, output logic [31:0] wd, output logic [3:0] ws);
    int unsigned r = $urandom_range(0, 9);
    if (r == 0)      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 1) a = 32'h400 + (32'($urandom_range(0, 1000)) << 2);
    else if (r == 2) a = {$urandom_range(1, 255) == 0 ? 8'h01 : 8'($urandom_range(1, 255)), 22'h0, 2'b00};
    else             a = 32'($urandom_range(0, 15)) << 2;
    wd = $urandom;
    ws = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
  endtask

  // Call just after a rising edge with the instance idle; the next edge accepts the request.
  task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    int lat;
    int exp_lat;
    logic [31:0] erd;
    logic eerr;
    exp_lat = (d == 0) ? 3 : 1;
    erd  = exp_rdata(d, a, ws);
    eerr = is_fault(a);
    valid[d] = 1'b1;
    addr[d]  = a;
    wdata[d] = wd;
    wstrb[d] = ws;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!ready[d]) begin
        check("quiet_out", rdata[d] | 32'(err[d]), 32'h0);
        addr[d]  = $urandom;
        wdata[d] = $urandom;
        wstrb[d] = 4'($urandom);
      end
    end while (!ready[d] && lat < 16);
    check("latency", 32'(lat), 32'(exp_lat));
    check("rdata", rdata[d], erd);
    check("err", 32'(err[d]), 32'(eerr));
    valid[d] = 1'b0;
    model_update(d, a, wd, ws);
  endtask

  // Back-to-back traffic with valid held high on the zero-wait instance.
  task automatic stream_b(input int n);
    logic [31:0] a, wd, erd;
    logic [3:0] ws;
    logic eerr;
    int cyc, last, got;
    pick(a, wd, ws);
    erd = exp_rdata(1, a, ws);
    eerr = is_fault(a);
    valid[1] = 1'b1; addr[1] = a; wdata[1] = wd; wstrb[1] = ws;
    @(posedge clk);
    cyc = 0; last = 0; got = 0;
    while (got < n && cyc < 4 * n + 4) begin
      @(negedge clk);
      cyc++;
      if (ready[1]) begin
        if (got == 0) check("b2b_first", 32'(cyc), 32'd1);
        else          check("b2b_gap", 32'(cyc - last), 32'd2);
        check("b2b_rdata", rdata[1], erd);
        check("b2b_err", 32'(err[1]), 32'(eerr));
        model_update(1, a, wd, ws);
        last = cyc;
        got++;
        if (got < n) begin
          pick(a, wd, ws);
          erd = exp_rdata(1, a, ws);
          eerr = is_fault(a);
          addr[1] = a; wdata[1] = wd; wstrb[1] = ws;
        end else begin
          valid[1] = 1'b0;
        end
      end
    end
    check("b2b_count", 32'(got), 32'(n));
    valid[1] = 1'b0;
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [3:0] ws;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(ready[d]), 32'h0);
      check("rst_rdata", rdata[d], 32'h0);
      check("rst_err", 32'(err[d]), 32'h0);
    end
    rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        xfer(d, 32'(4 * i), $urandom, 4'hF);
      end
    end

    // Store then load, byte strobes, and faults
    @(posedge clk); #1; xfer(0, 32'h10, 32'hDEADBEEF, 4'hF);
    @(posedge clk); #1; xfer(0, 32'h10, 32'h0, 4'h0);
    check("sw_lw_abs", rdata[0] == 32'hDEADBEEF ? 32'h0 : 32'h1, 32'h0);
    @(posedge clk); #1; xfer(0, 32'h20, 32'h11223344, 4'hF);
    @(posedge clk); #1; xfer(0, 32'h20, 32'hAABBCCDD, 4'b0101);
    @(posedge clk); #1; xfer(0, 32'h20, 32'h0, 4'h0);
    check("strobe_abs", model[0][8], 32'h11BB33DD);
    @(posedge clk); #1; xfer(0, 32'h402, 32'h0, 4'h0);
    @(posedge clk); #1; xfer(0, 32'h400, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1; xfer(0, 32'h0, 32'h0, 4'h0);

    // Abort in the first wait cycle, then an immediate new request
    @(posedge clk); #1;
    valid[0] = 1'b1; addr[0] = 32'h14; wdata[0] = 32'h5A5A5A5A; wstrb[0] = 4'hF;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready[0]), 32'h0);
    @(posedge clk); #1;
    xfer(0, 32'h14, 32'h0, 4'h0);

    // Reset during the wait of a store
    @(posedge clk); #1;
    valid[0] = 1'b1; addr[0] = 32'h18; wdata[0] = 32'h0BADF00D; wstrb[0] = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 32'(ready[0]), 32'h0);
    @(posedge clk); #1;
    check("rst_mid_after", 32'(ready[0]), 32'h0);
    rst = 1'b0;
    xfer(0, 32'h18, 32'h0, 4'h0);

    for (int i = 0; i < 40; i++) begin
      pick(a, wd, ws);
      @(posedge clk); #1;
      xfer(0, a, wd, ws);
    end

    @(posedge clk); #1;
    stream_b(12);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      xfer(1, 32'(4 * i), 32'h0, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
